// File: rtl/mms_pkg.sv
// Shared types and constants for the streaming max/min selector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mms_pkg;

    // Frame controller states: waiting for beat 0, accumulating, presenting result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mms_state_t;

    // Encoding of the select input.
    localparam logic MMS_SEL_MAX = 1'b0;
    localparam logic MMS_SEL_MIN = 1'b1;

endpackage

// File: rtl/mms_serial_if.sv
// Stream interface for mms_serial: sample input channel plus result output channel.
// Latency: n/a (wiring only).
// Backpressure: in_ready throttles the sample producer, out_ready throttles the result.
//
// Signals:
//   select/number/in_valid -> sample channel (producer drives), in_ready <- block
//   result/result_idx/out_valid <- block, out_ready -> consumer drives
// Modports: master = producer/consumer side, slave = the selector block.
interface mms_serial_if #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 8
);
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic              select;
    logic [DATA_W-1:0] number;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] result;
    logic [IDX_W-1:0]  result_idx;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output select, number, in_valid, out_ready,
        input  in_ready, result, result_idx, out_valid
    );

    modport slave (
        input  select, number, in_valid, out_ready,
        output in_ready, result, result_idx, out_valid
    );

endinterface

// File: rtl/mms_cmp_sel.sv
// Combinational 2-input compare-and-select between running winner and new candidate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, the caller decides whether to use it.
//
// Ports:
//   sel       in  0 = max, 1 = min
//   cur       in  current running winner
//   cand      in  new candidate sample
//   pick_cand out candidate replaces the current winner
//   value     out winning value after this compare
module mms_cmp_sel
    import mms_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] cand,
    output logic              pick_cand,
    output logic [DATA_W-1:0] value
);

    logic cur_lt_cand;

    // One unsigned comparator serves both modes. For max a tie keeps the
    // earlier sample (strict <); for min the negation makes a tie pick the
    // newer sample, so equal minima resolve to the latest index.
    assign cur_lt_cand = (cur < cand);
    assign pick_cand   = (sel == MMS_SEL_MIN) ? !cur_lt_cand : cur_lt_cand;
    assign value       = pick_cand ? cand : cur;

endmodule

// File: rtl/mms_serial.sv
// Streaming max/min selector: folds a FRAME_LEN-sample frame into its extreme value and index.
// Latency: out_valid rises on the edge accepting the last sample; min frame period FRAME_LEN+1.
// Backpressure: in_ready drops while a result is held; result held until out_ready.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of mms_serial_if (sample in, result out)
module mms_serial
    import mms_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mms_serial_if.slave  bus
);

    localparam int              IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    mms_state_t        state_q;
    mms_state_t        state_d;

    logic              sel_q;
    logic [DATA_W-1:0] acc_q;
    logic [IDX_W-1:0]  acc_idx_q;
    logic [IDX_W-1:0]  cnt_q;

    logic [DATA_W-1:0] result_q;
    logic [IDX_W-1:0]  result_idx_q;
    logic              out_valid_q;

    logic              in_ready;
    logic              accept;
    logic              last_beat;
    logic              pick_cand;
    logic [DATA_W-1:0] cmp_value;

    // Ready comes only from state and reset so the producer never sees a
    // combinational path from out_ready or in_valid.
    assign in_ready  = rst_n && (state_q != HOLD);
    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (state_q == ACCUM) && accept && (cnt_q == LAST_IDX);

    mms_cmp_sel #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .sel       (sel_q),
        .cur       (acc_q),
        .cand      (bus.number),
        .pick_cand (pick_cand),
        .value     (cmp_value)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = ACCUM;
            ACCUM:   if (last_beat)     state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q        <= MMS_SEL_MAX;
            acc_q        <= '0;
            acc_idx_q    <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            result_idx_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Beat 0 seeds the winner; select is frozen for the frame.
                        sel_q     <= bus.select;
                        acc_q     <= bus.number;
                        acc_idx_q <= '0;
                        cnt_q     <= IDX_W'(1);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (pick_cand) begin
                            acc_q     <= cmp_value;
                            acc_idx_q <= cnt_q;
                        end
                        if (last_beat) begin
                            // Publish the post-compare winner, not the stale accumulator.
                            result_q     <= cmp_value;
                            result_idx_q <= pick_cand ? cnt_q : acc_idx_q;
                            out_valid_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.result     = result_q;
    assign bus.result_idx = result_idx_q;
    assign bus.out_valid  = out_valid_q;

endmodule
